// File: rtl/kim_counter_datapath.sv
// Counter datapath for the counter control block: run/done driven count, a 2-entry
// report FIFO of completed runs, and run/pause/overflow status.
module kim_counter_datapath #(
  parameter int unsigned CNT_DATA_WIDTH = 7,
  parameter int unsigned RUNS_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run_i,
  input  logic                      done_i,
  input  logic                      clear_i,
  output logic [CNT_DATA_WIDTH-1:0] c_cnt_o,
  output logic                      busy_o,
  output logic                      paused_o,
  output logic                      rpt_valid_o,
  input  logic                      rpt_ready_i,
  output logic [CNT_DATA_WIDTH-1:0] rpt_cnt_o,
  output logic [RUNS_WIDTH-1:0]     rpt_runs_o,
  output logic                      overflow_o
);

  typedef enum logic [1:0] {StIdle, StCount, StPause} state_e;

  state_e                    state_q;
  logic [CNT_DATA_WIDTH-1:0] cnt_q;
  logic [RUNS_WIDTH-1:0]     runs_q;
  logic [RUNS_WIDTH-1:0]     runs_inc;
  logic                      done_q;
  logic                      push;
  logic                      pop;

  logic [CNT_DATA_WIDTH-1:0] head_cnt_q, tail_cnt_q;
  logic [RUNS_WIDTH-1:0]     head_runs_q, tail_runs_q;
  logic [1:0]                fill_q;
  logic                      ovf_q;

  assign runs_inc = runs_q + RUNS_WIDTH'(1);
  // A report is captured only on the rising edge of done; clear suppresses it.
  assign push     = done_i & ~done_q & ~clear_i;
  assign pop      = rpt_valid_o & rpt_ready_i & ~clear_i;

  // Control FSM, counter, run counter and done-edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      runs_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= done_i;
      if (clear_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        runs_q  <= '0;
      end else if (done_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        if (!done_q) runs_q <= runs_inc;
      end else if (run_i) begin
        state_q <= StCount;
        cnt_q   <= cnt_q + CNT_DATA_WIDTH'(1);
      end else if (state_q == StCount) begin
        state_q <= StPause;
      end
    end
  end

  // Two-entry report FIFO; the head registers hold their value after the last pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_cnt_q  <= '0;
      head_runs_q <= '0;
      tail_cnt_q  <= '0;
      tail_runs_q <= '0;
      fill_q      <= 2'd0;
      ovf_q       <= 1'b0;
    end else if (clear_i) begin
      head_cnt_q  <= '0;
      head_runs_q <= '0;
      tail_cnt_q  <= '0;
      tail_runs_q <= '0;
      fill_q      <= 2'd0;
      ovf_q       <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (fill_q == 2'd1) begin
            head_cnt_q  <= cnt_q;
            head_runs_q <= runs_inc;
          end else begin
            head_cnt_q  <= tail_cnt_q;
            head_runs_q <= tail_runs_q;
            tail_cnt_q  <= cnt_q;
            tail_runs_q <= runs_inc;
          end
        end
        2'b10: begin
          if (fill_q == 2'd0) begin
            head_cnt_q  <= cnt_q;
            head_runs_q <= runs_inc;
            fill_q      <= 2'd1;
          end else if (fill_q == 2'd1) begin
            tail_cnt_q  <= cnt_q;
            tail_runs_q <= runs_inc;
            fill_q      <= 2'd2;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        2'b01: begin
          if (fill_q == 2'd2) begin
            head_cnt_q  <= tail_cnt_q;
            head_runs_q <= tail_runs_q;
          end
          fill_q <= fill_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign c_cnt_o     = cnt_q;
  assign busy_o      = (state_q != StIdle);
  assign paused_o    = (state_q == StPause);
  assign rpt_valid_o = (fill_q != 2'd0);
  assign rpt_cnt_o   = head_cnt_q;
  assign rpt_runs_o  = head_runs_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_kim_counter_datapath.sv
// Directed bench for kim_counter_datapath; reports are scoreboarded through a queue.
module tb_kim_counter_datapath;

  localparam int unsigned CW = 7;
  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run_i = 1'b0;
  logic          done_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          rpt_ready_i = 1'b0;
  logic [CW-1:0] c_cnt_o;
  logic          busy_o;
  logic          paused_o;
  logic          rpt_valid_o;
  logic [CW-1:0] rpt_cnt_o;
  logic [RW-1:0] rpt_runs_o;
  logic          overflow_o;

  kim_counter_datapath #(.CNT_DATA_WIDTH(CW), .RUNS_WIDTH(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run_i),
    .done_i      (done_i),
    .clear_i     (clear_i),
    .c_cnt_o     (c_cnt_o),
    .busy_o      (busy_o),
    .paused_o    (paused_o),
    .rpt_valid_o (rpt_valid_o),
    .rpt_ready_i (rpt_ready_i),
    .rpt_cnt_o   (rpt_cnt_o),
    .rpt_runs_o  (rpt_runs_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected reports not yet consumed, {cnt, runs}.
  logic [CW+RW-1:0] sb[$];
  logic [CW-1:0]    exp_cnt = '0;
  logic [RW-1:0]    exp_runs = '0;
  logic             exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer side: compare the head against the scoreboard whenever it is accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rpt_valid", {31'd0, rpt_valid_o}, {31'd0, sb.size() != 0});
      if (rpt_valid_o && rpt_ready_i && sb.size() != 0) begin
        logic [CW+RW-1:0] e;
        e = sb.pop_front();
        chk("rpt_cnt", 32'(rpt_cnt_o), 32'(e[CW+RW-1:RW]));
        chk("rpt_runs", 32'(rpt_runs_o), 32'(e[RW-1:0]));
      end
    end
  end

  task automatic count(input int n);
    for (int i = 0; i < n; i++) begin
      run_i = 1'b1;
      @(posedge clk);
      exp_cnt = exp_cnt + CW'(1);
      #1;
      chk("c_cnt", 32'(c_cnt_o), 32'(exp_cnt));
      chk("busy", {31'd0, busy_o}, 32'd1);
      chk("paused", {31'd0, paused_o}, 32'd0);
    end
    run_i = 1'b0;
  endtask

  task automatic pause(input int n);
    run_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("pause_flag", {31'd0, paused_o}, 32'd1);
      chk("pause_cnt", 32'(c_cnt_o), 32'(exp_cnt));
    end
  endtask

  task automatic finish_run(input int done_len);
    run_i  = 1'b0;
    done_i = 1'b1;
    @(posedge clk);
    exp_runs = exp_runs + RW'(1);
    if (sb.size() < 2) sb.push_back({exp_cnt, exp_runs});
    else exp_ovf = 1'b1;
    exp_cnt = '0;
    #1;
    chk("done_cnt", 32'(c_cnt_o), 32'd0);
    chk("done_busy", {31'd0, busy_o}, 32'd0);
    chk("overflow", {31'd0, overflow_o}, {31'd0, exp_ovf});
    for (int i = 1; i < done_len; i++) begin
      @(posedge clk);
      #1;
    end
    done_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk);
    sb.delete();
    exp_cnt  = '0;
    exp_runs = '0;
    exp_ovf  = 1'b0;
    #1;
    clear_i = 1'b0;
    done_i  = 1'b0;
    chk("clr_cnt", 32'(c_cnt_o), 32'd0);
    chk("clr_busy", {31'd0, busy_o}, 32'd0);
    chk("clr_ovf", {31'd0, overflow_o}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #12;
    chk("rst_cnt", 32'(c_cnt_o), 32'd0);
    chk("rst_valid", {31'd0, rpt_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Basic run of 5, report visible the cycle after the done edge.
    rpt_ready_i = 1'b1;
    count(5);
    finish_run(1);
    chk("basic_valid", {31'd0, rpt_valid_o}, 32'd1);
    chk("basic_head", 32'(rpt_cnt_o), 32'd5);
    idle(2);

    // Three runs of 10 with the consumer always ready.
    do_clear();
    for (int r = 0; r < 3; r++) begin
      count(10);
      finish_run(1);
      idle(1);
    end

    // Pause in the middle of a run.
    count(3);
    pause(4);
    count(2);
    finish_run(1);
    idle(2);

    // Backpressure: third report dropped.
    do_clear();
    rpt_ready_i = 1'b0;
    count(2); finish_run(1);
    count(3); finish_run(1);
    count(4); finish_run(1);
    chk("bp_ovf", {31'd0, overflow_o}, 32'd1);
    rpt_ready_i = 1'b1;
    idle(3);
    chk("bp_empty", {31'd0, rpt_valid_o}, 32'd0);
    chk("bp_ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // Full FIFO with push and pop on the same edge: nothing dropped.
    do_clear();
    rpt_ready_i = 1'b0;
    count(1); finish_run(1);
    count(2); finish_run(1);
    count(3);
    rpt_ready_i = 1'b1;
    finish_run(1);
    chk("simul_ovf", {31'd0, overflow_o}, 32'd0);
    idle(3);

    // done held for three cycles gives one report.
    count(4);
    finish_run(3);
    idle(3);
    chk("held_runs", 32'(rpt_runs_o), 32'd4);

    // clear coincident with a done edge: no report, run counter back to 0.
    count(2);
    done_i = 1'b1;
    do_clear();
    chk("clrdone_valid", {31'd0, rpt_valid_o}, 32'd0);
    count(1);
    finish_run(1);
    idle(2);

    // Counter wrap: 130 increments land on 2.
    count(130);
    chk("wrap_cnt", 32'(c_cnt_o), 32'd2);
    finish_run(1);
    idle(2);

    // Asynchronous reset mid-run with a report pending.
    rpt_ready_i = 1'b0;
    count(2); finish_run(1);
    count(3);
    run_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_cnt = '0; exp_runs = '0; exp_ovf = 1'b0;
    run_i = 1'b0;
    chk("arst_cnt", 32'(c_cnt_o), 32'd0);
    chk("arst_valid", {31'd0, rpt_valid_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_rcnt", 32'(rpt_cnt_o), 32'd0);
    chk("arst_runs", 32'(rpt_runs_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rpt_ready_i = 1'b1;
    count(2);
    finish_run(1);
    idle(3);
    chk("final_empty", {31'd0, rpt_valid_o}, 32'd0);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kim_counter_datapath.md
Name: kim_counter_datapath

Overview:
- Counter datapath driven by the counter control FSM's run/done outputs. It produces the current count fed back to the control block as c_cnt.
- Records each completed run into a 2-entry report FIFO, drained by a downstream consumer over a valid/ready handshake.
- Tracks run count, pause state and report overflow for status/debug.

Parameters:
- CNT_DATA_WIDTH, 7, width of count value; matches control block.
- RUNS_WIDTH, 8, width of completed-run counter (wraps).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run_i  input  1  count enable from control (run_o)
- done_i  input  1  run-complete indication from control (done_o)
- clear_i  input  1  synchronous clear: counter, FSM, FIFO, run counter, overflow
- c_cnt_o  output  CNT_DATA_WIDTH  current count, to control c_cnt
- busy_o  output  1  high in S_COUNT or S_PAUSE
- paused_o  output  1  high in S_PAUSE
- rpt_valid_o  output  1  report FIFO non-empty
- rpt_ready_i  input  1  consumer accepts head report
- rpt_cnt_o  output  CNT_DATA_WIDTH  head report: final count of the run
- rpt_runs_o  output  RUNS_WIDTH  head report: run index (1-based, wraps)
- overflow_o  output  1  sticky: a report was dropped because FIFO was full

Behaviour:
- Reset (rst_n low, async): state S_IDLE, c_cnt_o 0, FIFO empty, rpt_valid_o 0, rpt_cnt_o 0, rpt_runs_o 0, run counter 0, overflow_o 0, busy_o 0, paused_o 0, done-edge register 0. Reset mid-run aborts the run with no report.
- Priority per cycle: clear_i > done_i > run_i > hold.
- FSM states: S_IDLE, S_COUNT, S_PAUSE.
  - S_IDLE: run_i & !done_i -> S_COUNT, c_cnt_o+1.
  - S_COUNT: done_i -> S_IDLE. run_i -> stay, increment. Neither -> S_PAUSE, hold.
  - S_PAUSE: done_i -> S_IDLE. run_i -> S_COUNT, increment. Else hold.
- Counter:
  - increment is modulo 2^CNT_DATA_WIDTH (max wraps to 0, no flag).
  - done_i forces c_cnt_o to 0 at the next edge regardless of run_i.
  - c_cnt_o is registered; 1-cycle latency from run_i to visible increment.
- Report capture:
  - Triggers on the done rising edge only (done_i high, registered done_i low); done_i held high produces one report.
  - Captured rpt_cnt = c_cnt_o value in that cycle (pre-clear). With the control block this equals cnt_val.
  - Run counter increments (mod 2^RUNS_WIDTH); the new value is stored as rpt_runs.
  - The run counter increments even when the report is dropped.
- FIFO:
  - 2 entries; rpt_* outputs show the head entry; rpt_valid_o = not empty.
  - Pop when rpt_valid_o & rpt_ready_i.
  - Push and pop in the same cycle are both honoured, including when full (no drop).
  - Push when full without pop: entry dropped, overflow_o set (sticky until clear_i or reset).
  - rpt_ready_i with FIFO empty: no effect.
  - rpt_cnt_o/rpt_runs_o hold the last popped value when empty (don't-care to consumer).
- clear_i: next edge c_cnt_o 0, S_IDLE, FIFO empty, run counter 0, overflow_o 0. clear_i coincident with a done edge: no report, run counter stays 0.
- busy_o and paused_o are decoded from registered state (no combinational path from inputs).

Test Plan:
- Basic run: run_i high 5 cycles then done_i 1 cycle -> c_cnt_o 1..5, then 0. Report rpt_cnt_o=5, rpt_runs_o=1, rpt_valid_o high the cycle after the done edge.
- Closed loop with control (cnt_val=10, start pulse) -> c_cnt_o reaches 10, one report rpt_cnt_o=10. Repeat 3 runs, rpt_ready_i=1 -> rpt_runs_o 1,2,3.
- Pause: run_i high 3 cycles, low 4, high 2, then done -> paused_o high 4 cycles with c_cnt_o held at 3; report rpt_cnt_o=5.
- Backpressure: rpt_ready_i=0, three runs of 2,3,4 counts -> FIFO holds (2,1),(3,2); third dropped, overflow_o=1. Then ready=1 -> pops 2 then 3, rpt_valid_o low.
- Simultaneous events: FIFO full, done edge and pop in same cycle -> no drop, overflow_o stays 0. done_i held 3 cycles -> single report. clear_i with done_i -> no report, counters 0.
- Wrap/reset: CNT_DATA_WIDTH=7, run 130 cycles -> c_cnt_o wraps 127->0->2. Assert rst_n low mid-run with FIFO non-empty -> all outputs 0 immediately (async).
